// File: rtl/shk_arbiter.sv
// shk_arbiter: round-robin arbiter joining four SHK masters onto one SHK slave.
// Ports: i_sys_clk / i_sys_rst_n (async, active-low).
//   s_shk_*  : four upstream masters (valid/maddr/mdata/msync in, ready out)
//              plus the slave response (saddr/sdata/ssync) broadcast back.
//   m_shk_0_*: downstream slave port.
//   o_grant  : one-hot current grant, 0 in IDLE.
//   o_unusual_flg : sticky timeout flag.
// Build option: define SHK_ARB_TIMEOUT_EN to enable the GRANT timeout of
// NM_TO_CYC cycles; without it the flag is constant 0 and GRANT waits forever.
module shk_arbiter #(
   parameter int WD_SHK_DAT = 32,
   parameter int WD_SHK_ADR = 32,
   parameter int NM_TO_CYC  = 255
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_rst_n,
   input  logic [3:0]              s_shk_valid,
   input  logic [4*WD_SHK_ADR-1:0] s_shk_maddr,
   input  logic [4*WD_SHK_DAT-1:0] s_shk_mdata,
   input  logic [3:0]              s_shk_msync,
   output logic [3:0]              s_shk_ready,
   output logic [WD_SHK_ADR-1:0]   s_shk_saddr,
   output logic [WD_SHK_DAT-1:0]   s_shk_sdata,
   output logic                    s_shk_ssync,
   output logic                    m_shk_0_valid,
   output logic [WD_SHK_ADR-1:0]   m_shk_0_maddr,
   output logic [WD_SHK_DAT-1:0]   m_shk_0_mdata,
   output logic                    m_shk_0_msync,
   input  logic                    m_shk_0_ready,
   input  logic [WD_SHK_ADR-1:0]   m_shk_0_saddr,
   input  logic [WD_SHK_DAT-1:0]   m_shk_0_sdata,
   input  logic                    m_shk_0_ssync,
   output logic [3:0]              o_grant,
   output logic                    o_unusual_flg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [1:0]            gidx_q, gidx_d;
   logic [3:0]            grant_q, grant_d;
   logic [WD_SHK_ADR-1:0] maddr_q, maddr_d;
   logic [WD_SHK_DAT-1:0] mdata_q, mdata_d;
   logic                  msync_q, msync_d;

`ifdef SHK_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(NM_TO_CYC - 1);
   logic [15:0]           cnt_q, cnt_d;
   logic                  flg_q, flg_d;
`endif

   logic [1:0]            pick;
   logic [1:0]            cand;
   logic                  in_grant;
   logic                  sel_valid;
   logic                  sel_msync;
   logic [WD_SHK_ADR-1:0] sel_maddr;
   logic [WD_SHK_DAT-1:0] sel_mdata;

   // Scan from the lowest priority up so the requester nearest the pointer wins.
   always_comb begin
      pick = ptr_q;
      cand = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (s_shk_valid[cand]) pick = cand;
      end
   end

   assign in_grant  = (state_q == GRANT);
   assign sel_valid = s_shk_valid[gidx_q];
   assign sel_msync = s_shk_msync[gidx_q];
   assign sel_maddr = s_shk_maddr[int'(gidx_q)*WD_SHK_ADR +: WD_SHK_ADR];
   assign sel_mdata = s_shk_mdata[int'(gidx_q)*WD_SHK_DAT +: WD_SHK_DAT];

   // Request side is a live mux in GRANT and a held copy elsewhere.
   assign m_shk_0_valid = in_grant & sel_valid;
   assign m_shk_0_maddr = in_grant ? sel_maddr : maddr_q;
   assign m_shk_0_mdata = in_grant ? sel_mdata : mdata_q;
   assign m_shk_0_msync = in_grant ? sel_msync : msync_q;
   assign s_shk_ready   = in_grant ? (4'(m_shk_0_ready) << gidx_q) : 4'd0;

   assign s_shk_saddr = m_shk_0_saddr;
   assign s_shk_sdata = m_shk_0_sdata;
   assign s_shk_ssync = m_shk_0_ssync;

   assign o_grant = grant_q;

`ifdef SHK_ARB_TIMEOUT_EN
   assign o_unusual_flg = flg_q;
`else
   // Never true for a legal NM_TO_CYC, so the flag is constant 0.
   assign o_unusual_flg = (NM_TO_CYC < 0);
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      maddr_d = maddr_q;
      mdata_d = mdata_q;
      msync_d = msync_q;
`ifdef SHK_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      flg_d   = flg_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|s_shk_valid) begin
               state_d = GRANT;
               gidx_d  = pick;
               grant_d = 4'b0001 << pick;
               ptr_d   = pick + 2'd1;
`ifdef SHK_ARB_TIMEOUT_EN
               cnt_d   = 16'd0;
`endif
            end
         end
         GRANT: begin
            maddr_d = sel_maddr;
            mdata_d = sel_mdata;
            msync_d = sel_msync;
            if (!sel_valid) begin
               state_d = IDLE;
               grant_d = 4'd0;
            end else if (m_shk_0_ready) begin
               state_d = RELEASE;
            end
`ifdef SHK_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == TO_LAST) begin
                  flg_d   = 1'b1;
                  state_d = RELEASE;
               end
            end
`endif
         end
         RELEASE: begin
            if (!m_shk_0_ready) begin
               state_d = IDLE;
               grant_d = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         gidx_q  <= 2'd0;
         grant_q <= 4'd0;
         maddr_q <= '0;
         mdata_q <= '0;
         msync_q <= 1'b0;
`ifdef SHK_ARB_TIMEOUT_EN
         cnt_q   <= 16'd0;
         flg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         maddr_q <= maddr_d;
         mdata_q <= mdata_d;
         msync_q <= msync_d;
`ifdef SHK_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         flg_q   <= flg_d;
`endif
      end
   end

endmodule

// File: tb/tb_shk_arbiter.sv
// tb_shk_arbiter: directed bench for shk_arbiter with a handshake scoreboard.
// Masters, slave and monitor run as separate processes.
module tb_shk_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    s_valid;
   logic [4*AW-1:0] s_maddr;
   logic [4*DW-1:0] s_mdata;
   logic [3:0]    s_msync;
   logic [3:0]    s_ready;
   logic [AW-1:0] s_saddr;
   logic [DW-1:0] s_sdata;
   logic          s_ssync;
   logic          m_valid;
   logic [AW-1:0] m_maddr;
   logic [DW-1:0] m_mdata;
   logic          m_msync;
   logic          m_ready;
   logic [AW-1:0] m_saddr;
   logic [DW-1:0] m_sdata;
   logic          m_ssync;
   logic [3:0]    o_grant;
   logic          o_flg;

   always #5 clk = ~clk;

   shk_arbiter #(
      .WD_SHK_DAT(DW),
      .WD_SHK_ADR(AW),
      .NM_TO_CYC (8)
   ) dut (
      .i_sys_clk    (clk),
      .i_sys_rst_n  (rst_n),
      .s_shk_valid  (s_valid),
      .s_shk_maddr  (s_maddr),
      .s_shk_mdata  (s_mdata),
      .s_shk_msync  (s_msync),
      .s_shk_ready  (s_ready),
      .s_shk_saddr  (s_saddr),
      .s_shk_sdata  (s_sdata),
      .s_shk_ssync  (s_ssync),
      .m_shk_0_valid(m_valid),
      .m_shk_0_maddr(m_maddr),
      .m_shk_0_mdata(m_mdata),
      .m_shk_0_msync(m_msync),
      .m_shk_0_ready(m_ready),
      .m_shk_0_saddr(m_saddr),
      .m_shk_0_sdata(m_sdata),
      .m_shk_0_ssync(m_ssync),
      .o_grant      (o_grant),
      .o_unusual_flg(o_flg)
   );

   typedef struct {
      int m;
      int k;
   } exp_t;

   exp_t exp_q[$];
   int   n_tot = 0;
   int   n_pass = 0;
   int   req_tot[4];
   int   hs_tot[4];
   int   k_exp[4];
   bit   slv_hold;
   int   slv_dly;
   bit   multi_hot = 1'b0;

   function automatic logic [31:0] f_addr(input int m, input int k);
      return 32'hA000_0000 | 32'(m << 8) | 32'(k);
   endfunction

   function automatic logic [31:0] f_data(input int m, input int k);
      return 32'hD000_0000 | 32'(m << 12) | 32'(k * 3);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic issue(input int m);
      req_tot[m]++;
   endtask

   task automatic expect_hs(input int m);
      exp_q.push_back('{m, k_exp[m]});
      k_exp[m]++;
   endtask

   task automatic wait_grant(input logic [3:0] g);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_grant !== g && n < 50);
      chk("wait_grant", 32'(o_grant), 32'(g));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || o_grant != 4'd0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_grant", 32'(o_grant), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Masters: master i holds valid while it has unserved requests.
   initial begin
      s_valid = '0;
      s_maddr = '0;
      s_mdata = '0;
      s_msync = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < 4; i++) begin
            s_valid[i] = (req_tot[i] > hs_tot[i]);
            s_maddr[i*AW +: AW] = f_addr(i, hs_tot[i]);
            s_mdata[i*DW +: DW] = f_data(i, hs_tot[i]);
            s_msync[i] = ((hs_tot[i] & 1) != 0);
         end
      end
   end

   // Slave: ready rises slv_dly cycles into a valid, drops after the handshake.
   initial begin
      int cnt;
      cnt = 0;
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (slv_hold || !rst_n) begin
            m_ready = 1'b0;
            cnt = 0;
         end else if (m_ready) begin
            m_ready = 1'b0;
            cnt = 0;
         end else if (m_valid) begin
            cnt++;
            if (cnt >= slv_dly) m_ready = 1'b1;
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: scores each handshake and the RELEASE cycle after it.
   initial begin
      exp_t       e;
      bit         post_hs;
      logic [3:0] last_g;
      post_hs = 1'b0;
      last_g = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (post_hs) begin
               chk("rel_valid", 32'(m_valid), 32'd0);
               chk("rel_ready", 32'(s_ready), 32'd0);
               chk("rel_grant", 32'(o_grant), 32'(last_g));
               post_hs = 1'b0;
            end
            if (m_valid && m_ready) begin
               for (int i = 0; i < 4; i++)
                  if (s_ready[i] && s_valid[i]) hs_tot[i]++;
               if (exp_q.size() == 0) begin
                  chk("unexp_hs", 32'(o_grant), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("hs_grant", 32'(o_grant), 32'(1 << e.m));
                  chk("hs_ready", 32'(s_ready), 32'(1 << e.m));
                  chk("hs_maddr", m_maddr, f_addr(e.m, e.k));
                  chk("hs_mdata", m_mdata, f_data(e.m, e.k));
                  chk("hs_msync", 32'(m_msync), 32'(e.k & 1));
               end
               post_hs = 1'b1;
               last_g = o_grant;
            end
            if ($countones(o_grant) > 1) multi_hot = 1'b1;
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 4; i++) begin
         req_tot[i] = 0;
         hs_tot[i] = 0;
         k_exp[i] = 0;
      end
      slv_hold = 1'b1;
      slv_dly = 1;
      m_saddr = 32'h5A5A_0001;
      m_sdata = 32'hC0DE_0001;
      m_ssync = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_flag", 32'(o_flg), 32'd0);
      chk("rst_mvalid", 32'(m_valid), 32'd0);
      chk("rst_sready", 32'(s_ready), 32'd0);
      chk("rst_maddr", m_maddr, 32'd0);
      chk("rst_mdata", m_mdata, 32'd0);
      chk("rst_msync", 32'(m_msync), 32'd0);
      chk("pass_saddr", s_saddr, 32'h5A5A_0001);
      chk("pass_sdata", s_sdata, 32'hC0DE_0001);
      chk("pass_ssync", 32'(s_ssync), 32'd1);
      rst_n = 1'b1;

      // single master, two requests, slave ready 3 cycles after valid
      slv_hold = 1'b0;
      slv_dly = 3;
      issue(0);
      issue(0);
      expect_hs(0);
      expect_hs(0);
      drain();
      chk("hold_maddr", m_maddr, f_addr(0, 1));
      chk("hold_mdata", m_mdata, f_data(0, 1));
      chk("hold_msync", 32'(m_msync), 32'd1);
      chk("idle_mvalid", 32'(m_valid), 32'd0);
      m_saddr = 32'h0BAD_F00D;
      m_ssync = 1'b0;
      #1;
      chk("pass_saddr2", s_saddr, 32'h0BAD_F00D);
      chk("pass_ssync2", 32'(s_ssync), 32'd0);

      // all four requesting continuously: order 0,1,2,3,0
      do_reset();
      slv_dly = 2;
      issue(0);
      issue(0);
      issue(1);
      issue(2);
      issue(3);
      expect_hs(0);
      expect_hs(1);
      expect_hs(2);
      expect_hs(3);
      expect_hs(0);
      drain();

      // master 3 arrives while master 1 is granted: no preemption
      do_reset();
      slv_dly = 4;
      issue(1);
      expect_hs(1);
      expect_hs(3);
      wait_grant(4'b0010);
      issue(3);
      repeat (2) @(negedge clk);
      chk("nopre_grant", 32'(o_grant), 32'b0010);
      chk("nopre_rdy3", 32'(s_ready[3]), 32'd0);
      chk("nopre_maddr", m_maddr, f_addr(1, k_exp[1] - 1));
      drain();

      // async reset while master 2 is granted
      do_reset();
      slv_hold = 1'b1;
      issue(2);
      wait_grant(4'b0100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_grant", 32'(o_grant), 32'd0);
      chk("arst_mvalid", 32'(m_valid), 32'd0);
      chk("arst_sready", 32'(s_ready), 32'd0);
      req_tot[2]--;
      repeat (2) @(negedge clk);
      issue(0);
      issue(2);
      expect_hs(0);
      expect_hs(2);
      slv_hold = 1'b0;
      slv_dly = 1;
      @(negedge clk);
      rst_n = 1'b1;
      drain();

      // master 0 withdraws without a handshake; pointer still advances
      do_reset();
      slv_hold = 1'b1;
      issue(0);
      wait_grant(4'b0001);
      req_tot[0]--;
      repeat (3) @(negedge clk);
      chk("drop_grant", 32'(o_grant), 32'd0);
      chk("drop_flag", 32'(o_flg), 32'd0);
      chk("drop_mvalid", 32'(m_valid), 32'd0);
      slv_hold = 1'b0;
      slv_dly = 1;
      issue(0);
      issue(1);
      expect_hs(1);
      expect_hs(0);
      drain();

      // GRANT with the slave never ready
      do_reset();
      slv_hold = 1'b1;
      issue(2);
      wait_grant(4'b0100);
`ifdef SHK_ARB_TIMEOUT_EN
      n = 0;
      while (!o_flg && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", 32'(n), 32'd8);
      chk("to_rel_grant", 32'(o_grant), 32'b0100);
      chk("to_rel_valid", 32'(m_valid), 32'd0);
      req_tot[2]--;
      repeat (3) @(negedge clk);
      chk("to_idle_grant", 32'(o_grant), 32'd0);
      chk("to_flag_sticky", 32'(o_flg), 32'd1);
`else
      n = 0;
      repeat (20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_grant_held", 32'(o_grant), 32'b0100);
      chk("wait_flag", 32'(o_flg), 32'd0);
      chk("wait_mvalid", 32'(m_valid), 32'd1);
      req_tot[2]--;
      repeat (3) @(negedge clk);
      chk("wait_idle_grant", 32'(o_grant), 32'd0);
`endif

      chk("one_hot", 32'(multi_hot), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
